// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port data RAM.
// One transaction in flight; reads wait MEM_LAT cycles, then return data on a rvalid pulse.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_last, w_last_nxt;
    logic          r_port, w_port_nxt;
    logic          r_we, w_we_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_gnt0, r_gnt1, r_rvalid0, r_rvalid1, r_busy, r_mem_en, r_mem_we;
    logic          w_gnt0_nxt, w_gnt1_nxt, w_rvalid0_nxt, w_rvalid1_nxt;
    logic          w_busy_nxt, w_mem_en_nxt, w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DW-1:0] r_rdata, w_rdata_nxt;
    logic          w_sel;

    // On a tie the port that did not win last time is picked.
    assign w_sel = (req0 && req1) ? ~r_last : req1;

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_port_nxt      = r_port;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_gnt0_nxt      = 1'b0;
        w_gnt1_nxt      = 1'b0;
        w_rvalid0_nxt   = 1'b0;
        w_rvalid1_nxt   = 1'b0;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt     = S_ISSUE;
                    w_last_nxt      = w_sel;
                    w_port_nxt      = w_sel;
                    w_we_nxt        = w_sel ? we1 : we0;
                    w_mem_addr_nxt  = w_sel ? addr1 : addr0;
                    w_mem_wdata_nxt = w_sel ? wdata1 : wdata0;
                    w_gnt0_nxt      = ~w_sel;
                    w_gnt1_nxt      = w_sel;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = w_sel ? we1 : we0;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = LAT_INIT;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                // Last wait cycle: memory data is valid now, capture it.
                if (r_cnt == 4'd1) begin
                    w_rdata_nxt   = mem_rdata;
                    w_rvalid0_nxt = ~r_port;
                    w_rvalid1_nxt = r_port;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= 4'd0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_last      <= w_last_nxt;
            r_port      <= w_port_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt0      <= w_gnt0_nxt;
            r_gnt1      <= w_gnt1_nxt;
            r_rvalid0   <= w_rvalid0_nxt;
            r_rvalid1   <= w_rvalid1_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU data port (port 0) and the program/debug loader (port 1). It accepts one request at a time, grants round-robin on contention, drives the memory with registered strobes, and returns read data after the memory's fixed read latency. It sits between the core's load/store bus and the data RAM, and is the only master of the RAM.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 2, memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..15
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req0` / `req1`  in  1  request from port 0 / port 1
- `we0` / `we1`  in  1  1 = write, 0 = read; qualified by `reqN`
- `addr0` / `addr1`  in  AW  request address
- `wdata0` / `wdata1`  in  DW  write data
- `gnt0` / `gnt1`  out  1  one-cycle pulse: request accepted and issued to memory this cycle
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` valid for that port's read
- `rdata`  out  DW  read data; shared by both ports, qualified by `rvalidN`
- `busy`  out  1  high whenever state is not IDLE
- `mem_en`  out  1  memory access strobe, one cycle per transaction
- `mem_we`  out  1  memory write enable, valid with `mem_en`
- `mem_addr`  out  AW  memory address, valid with `mem_en`
- `mem_wdata`  out  DW  memory write data, valid with `mem_en`
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after `mem_en`

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: sample `req0`/`req1`. If neither is high, stay. If exactly one is high, select it. If both are high, select the port that was not granted last.
- IDLE with a selection: latch port id, `we`, `addr`, `wdata`. Go to ISSUE and update `last` to the selected port.
- ISSUE: `mem_en`=1, `mem_we`/`mem_addr`/`mem_wdata` = latched values, `gntN`=1 for the selected port.
  - Write: next state IDLE.
  - Read: load `cnt`=`MEM_LAT`, next state WAIT.
- WAIT: decrement `cnt` each cycle. When `cnt`==1, capture `mem_rdata` into `rdata` and go to RESP.
- RESP: `rvalidN`=1 for the latched port. Next state IDLE.
- A requester holds `reqN`, `weN`, `addrN` and `wdataN` stable until it sees `gntN`, then deasserts `reqN` by the following edge. The arbiter ignores all requests outside IDLE.
- At most one outstanding transaction. There is no pipelining of a second request behind a read.
- `rdata` holds its last captured value until the next capture. Reset value is 0.
- Non-ISSUE values are `mem_en`=0 and `mem_we`=0. `mem_addr` and `mem_wdata` hold their last values.
- Reset, asynchronous, in any state:
  - state=IDLE, `last`=port 1 (so port 0 wins the first tie), `cnt`=0.
  - All outputs 0: `gnt*`, `rvalid*`, `busy`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `rdata`.
  - An in-flight read is dropped and no `rvalid` is produced for it.

## Timing
- Request seen in IDLE in cycle T → `mem_en` and `gntN` in cycle T+1 (call it C).
- Write: state is IDLE again in C+1. The next grant is no earlier than C+2. Back-to-back writes from one port therefore occupy 1 of every 2 cycles.
- Read: `mem_rdata` is sampled at the end of cycle C+`MEM_LAT`. `rvalidN` and `rdata` appear in cycle C+`MEM_LAT`+1. State is IDLE in C+`MEM_LAT`+2.
- Read latency from request to `rvalid` is `MEM_LAT`+2 cycles. Spacing between read grants is `MEM_LAT`+3 cycles.
- `busy` is high in ISSUE, WAIT and RESP.
- `gnt0` and `gnt1` are never high in the same cycle. The same holds for `rvalid0` and `rvalid1`.
- `MEM_LAT`=1: WAIT lasts exactly one cycle.

## Test plan
- Single read, `MEM_LAT`=2:
  - Stimulus: `req0`=1, `we0`=0, `addr0`=0x10 in cycle 0; memory returns 0xDEADBEEF two cycles after `mem_en`.
  - Response: `gnt0`, `mem_en`=1, `mem_addr`=0x10 in cycle 1; `rvalid0`=1, `rdata`=0xDEADBEEF in cycle 4; `busy` high in cycles 1–4.
- Single write:
  - Stimulus: `req1`=1, `we1`=1, `addr1`=0x20, `wdata1`=0x12345678.
  - Response: `gnt1`, `mem_en`=1, `mem_we`=1 with that address and data one cycle later; no `rvalid1`; IDLE the cycle after.
- Contention:
  - Stimulus: both ports hold read requests continuously after reset.
  - Response: grant order is port 0, 1, 0, 1. Each `rvalid` goes to the port granted in that transaction and carries the data for its address.
- Reset mid-read:
  - Stimulus: assert `rst` during WAIT.
  - Response: all outputs 0 immediately, without waiting for a clock edge; no `rvalid` after `rst` deasserts; the next tie grants port 0.
- Latency sweep:
  - Stimulus: repeat the single-read test with `MEM_LAT`=1 and `MEM_LAT`=7.
  - Response: `rvalid` arrives 3 and 9 cycles after the request cycle respectively.
- Request hold:
  - Stimulus: `req1` rises while a port-0 read is in WAIT.
  - Response: no `gnt1` until the arbiter returns to IDLE; `gnt1` in the cycle after that IDLE.
